// File: rtl/pmem_port_pkg.sv
// Shared constants and types for the pmem_port memory responder.
// Holds the default sizes, the memory select encoding and the FSM state type.
package pmem_port_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    localparam logic MEM_PROG = 1'b0;
    localparam logic MEM_DATA = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

endpackage

// File: rtl/pmem_bank.sv
// One memory array: single write port plus a registered read port.
// The read register holds its value until the next read enable.
module pmem_bank #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset so a reload survives a reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Sampling before the same-edge write lands gives read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_port.sv
// Memory-side responder for the execute unit: program and data banks,
// execute-unit write/read ports and a byte-serial valid/ready loader.
module pmem_port
    import pmem_port_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmem_we,
    input  logic              pmem_d_type,
    input  logic [ADDR_W-1:0] pmem_w_addr,
    input  logic [DATA_W-1:0] pmem_out,
    input  logic              rd_req,
    input  logic              rd_type,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] pmem_in,
    output logic              rd_valid,
    input  logic              ld_start,
    input  logic              ld_type,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              wr_drop,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              ld_type_q, ld_type_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic              ld_done_q, ld_done_d;
    logic              wr_drop_q, wr_drop_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_sel_q;

    logic              ex_we, ld_we, rd_acc;
    logic              wr_tgt;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              prog_we, data_we, prog_re, data_re;
    logic [DATA_W-1:0] prog_rdata, data_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ld_type_q  <= MEM_PROG;
            ld_addr_q  <= '0;
            ld_done_q  <= 1'b0;
            wr_drop_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= MEM_PROG;
        end else begin
            state_q    <= state_d;
            ld_type_q  <= ld_type_d;
            ld_addr_q  <= ld_addr_d;
            ld_done_q  <= ld_done_d;
            wr_drop_q  <= wr_drop_d;
            rd_valid_q <= rd_valid_d;
            if (rd_acc) begin
                rd_sel_q <= rd_type;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ld_type_d  = ld_type_q;
        ld_addr_d  = ld_addr_q;
        ld_done_d  = 1'b0;
        wr_drop_d  = 1'b0;
        ld_ready   = 1'b0;
        busy       = 1'b0;
        ex_we      = 1'b0;
        ld_we      = 1'b0;
        rd_acc     = 1'b0;
        case (state_q)
            IDLE: begin
                ex_we  = pmem_we;
                rd_acc = rd_req;
                if (ld_start) begin
                    state_d   = LOAD;
                    ld_type_d = ld_type;
                    ld_addr_d = '0;
                end
            end
            LOAD: begin
                ld_ready  = 1'b1;
                busy      = 1'b1;
                wr_drop_d = pmem_we;
                // A restart wins over any byte offered in the same cycle.
                if (ld_start) begin
                    ld_type_d = ld_type;
                    ld_addr_d = '0;
                end else if (ld_valid) begin
                    ld_we     = 1'b1;
                    ld_addr_d = ld_addr_q + 1'b1;
                    if (ld_addr_q == {ADDR_W{1'b1}}) begin
                        state_d   = IDLE;
                        ld_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rd_valid_d = rd_acc;
    end

    // Loader and execute writes are mutually exclusive by state.
    assign wr_tgt  = ld_we ? ld_type_q : pmem_d_type;
    assign wr_addr = ld_we ? ld_addr_q : pmem_w_addr;
    assign wr_data = ld_we ? ld_data   : pmem_out;

    assign prog_we = (ex_we | ld_we) && (wr_tgt == MEM_PROG);
    assign data_we = (ex_we | ld_we) && (wr_tgt == MEM_DATA);
    assign prog_re = rd_acc && (rd_type == MEM_PROG);
    assign data_re = rd_acc && (rd_type == MEM_DATA);

    pmem_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_prog (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (prog_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (prog_re),
        .raddr_i (rd_addr),
        .rdata_o (prog_rdata)
    );

    pmem_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (data_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (data_re),
        .raddr_i (rd_addr),
        .rdata_o (data_rdata)
    );

    // Each bank only updates on its own read, so the last selection holds pmem_in.
    assign pmem_in  = (rd_sel_q == MEM_DATA) ? data_rdata : prog_rdata;
    assign rd_valid = rd_valid_q;
    assign ld_done  = ld_done_q;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_pmem_port.sv
// Self-checking bench for pmem_port: reference memories feed a read scoreboard,
// scenario tasks check loader, write-drop, restart and reset behaviour.
module tb_pmem_port;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pmem_we, pmem_d_type;
    logic [5:0] pmem_w_addr;
    logic [7:0] pmem_out;
    logic       rd_req, rd_type;
    logic [5:0] rd_addr;
    logic [7:0] pmem_in;
    logic       rd_valid;
    logic       ld_start, ld_type, ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready, ld_done, wr_drop, busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];
    logic [7:0] prog_m [64];
    logic [7:0] data_m [64];
    logic [7:0] mon_e;

    always #5 clk = ~clk;

    pmem_port dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pmem_we     (pmem_we),
        .pmem_d_type (pmem_d_type),
        .pmem_w_addr (pmem_w_addr),
        .pmem_out    (pmem_out),
        .rd_req      (rd_req),
        .rd_type     (rd_type),
        .rd_addr     (rd_addr),
        .pmem_in     (pmem_in),
        .rd_valid    (rd_valid),
        .ld_start    (ld_start),
        .ld_type     (ld_type),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_done     (ld_done),
        .wr_drop     (wr_drop),
        .busy        (busy)
    );

    // Scoreboard: every rd_valid must match the oldest pending expected read.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: rd_valid=1 pmem_in=%h, required no read pending", pmem_in);
            end else begin
                mon_e = exp_q.pop_front();
                if (pmem_in !== mon_e) begin
                    failures++;
                    $display("FAIL rd_data: pmem_in=%h required=%h", pmem_in, mon_e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pmem_in, rd_valid, ld_ready, ld_done, wr_drop, busy} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs: got pmem_in=%h rd_valid=%b ld_ready=%b ld_done=%b wr_drop=%b busy=%b, required all 0",
                     pmem_in, rd_valid, ld_ready, ld_done, wr_drop, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_load_prog();
        int ndone = 0;
        ld_start = 1'b1; ld_type = 1'b0;
        cyc();
        ld_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_enter: busy=%b ld_ready=%b required 1 1", busy, ld_ready);
        end
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i) ^ 8'hA5;
            prog_m[i] = ld_data;
            cyc();
            if (ld_done === 1'b1) ndone++;
            checks++;
            if (ld_done !== (i == 63)) begin
                failures++;
                $display("FAIL load_done_timing: byte=%0d ld_done=%b required=%b", i, ld_done, (i == 63));
            end
        end
        ld_valid = 1'b0;
        cyc();
        checks++;
        if (ndone != 1 || busy !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0) begin
            failures++;
            $display("FAIL load_finish: done_pulses=%0d busy=%b ld_ready=%b ld_done=%b required 1 0 0 0",
                     ndone, busy, ld_ready, ld_done);
        end
        // Expected values from the stated formula, cross-checked with the model.
        for (int k = 0; k < 3; k++) begin
            int a;
            logic [7:0] want;
            a    = (k == 0) ? 0 : (k == 1) ? 31 : 63;
            want = (k == 0) ? 8'hA5 : (k == 1) ? 8'hBA : 8'h9A;
            checks++;
            if (prog_m[a] !== want) begin
                failures++;
                $display("FAIL load_model: addr=%0d model=%h required=%h", a, prog_m[a], want);
            end
            rd_req = 1'b1; rd_type = 1'b0; rd_addr = 6'(a);
            exp_q.push_back(want);
            cyc();
        end
        rd_req = 1'b0;
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL load_read_latency: pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_exec_write();
        pmem_we = 1'b1; pmem_d_type = 1'b1; pmem_w_addr = 6'd5; pmem_out = 8'h42;
        data_m[5] = 8'h42;
        cyc();
        pmem_we = 1'b0;
        rd_req = 1'b1; rd_type = 1'b1; rd_addr = 6'd5;
        exp_q.push_back(8'h42);
        cyc();
        rd_type = 1'b0;
        exp_q.push_back(prog_m[5]);
        cyc();
        rd_req = 1'b0;
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL exec_read_latency: pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_collision();
        pmem_we = 1'b1; pmem_d_type = 1'b1; pmem_w_addr = 6'd7; pmem_out = 8'h10;
        data_m[7] = 8'h10;
        cyc();
        pmem_out = 8'h20;
        rd_req = 1'b1; rd_type = 1'b1; rd_addr = 6'd7;
        exp_q.push_back(data_m[7]);
        data_m[7] = 8'h20;
        cyc();
        pmem_we = 1'b0;
        exp_q.push_back(data_m[7]);
        cyc();
        rd_req = 1'b0;
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL collision_pending: pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_write_during_load();
        ld_start = 1'b1; ld_type = 1'b1;
        cyc();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = 8'(i) + 8'h30; data_m[i] = ld_data;
            cyc();
        end
        ld_valid = 1'b0;
        pmem_we = 1'b1; pmem_d_type = 1'b0; pmem_w_addr = 6'd5; pmem_out = 8'hFF;
        rd_req = 1'b1; rd_type = 1'b0; rd_addr = 6'd5;
        cyc();
        pmem_we = 1'b0; rd_req = 1'b0;
        checks++;
        if (wr_drop !== 1'b1 || busy !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_wr_drop: wr_drop=%b busy=%b rd_valid=%b required 1 1 0", wr_drop, busy, rd_valid);
        end
        cyc();
        checks++;
        if (wr_drop !== 1'b0) begin
            failures++;
            $display("FAIL load_wr_drop_pulse: wr_drop=%b required 0", wr_drop);
        end
        for (int i = 3; i < 64; i++) begin
            ld_valid = 1'b1; ld_data = 8'(i) + 8'h30; data_m[i] = ld_data;
            cyc();
        end
        ld_valid = 1'b0;
        checks++;
        if (ld_done !== 1'b1) begin
            failures++;
            $display("FAIL data_load_done: ld_done=%b required 1", ld_done);
        end
        cyc();
        rd_req = 1'b1; rd_type = 1'b0; rd_addr = 6'd5;
        exp_q.push_back(prog_m[5]);
        cyc();
        rd_type = 1'b1; rd_addr = 6'd2;
        exp_q.push_back(data_m[2]);
        cyc();
        rd_req = 1'b0;
        cyc();
    endtask

    task automatic test_restart_backpressure();
        int n = 0;
        int budget = 0;
        int ndone = 0;
        ld_start = 1'b1; ld_type = 1'b0;
        cyc();
        ld_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1; ld_data = 8'(i) + 8'h80; prog_m[i] = ld_data;
            cyc();
        end
        // Restart to data memory; the byte offered alongside must be discarded.
        ld_start = 1'b1; ld_type = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE;
        cyc();
        ld_start = 1'b0;
        while (n < 64 && budget < 2000) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            ld_valid = v;
            ld_data  = 8'(n) ^ 8'h3C;
            if (v) data_m[n] = ld_data;
            cyc();
            if (ld_done === 1'b1) ndone++;
            checks++;
            if (ld_done !== (v && n == 63)) begin
                failures++;
                $display("FAIL restart_done_timing: accepted=%0d ld_done=%b required=%b", n, ld_done, (v && n == 63));
            end
            if (v) n++;
            budget++;
        end
        ld_valid = 1'b0;
        checks++;
        if (n != 64 || ndone != 1) begin
            failures++;
            $display("FAIL restart_complete: accepted=%0d done_pulses=%0d required 64 1", n, ndone);
        end
        cyc();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL restart_idle: busy=%b required 0", busy);
        end
        rd_req = 1'b1; rd_type = 1'b1; rd_addr = 6'd0;
        exp_q.push_back(8'h3C);
        cyc();
        rd_addr = 6'd63;
        exp_q.push_back(data_m[63]);
        cyc();
        rd_type = 1'b0; rd_addr = 6'd10;
        exp_q.push_back(prog_m[10]);
        cyc();
        rd_addr = 6'd0;
        exp_q.push_back(8'h80);
        cyc();
        rd_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_midload();
        ld_start = 1'b1; ld_type = 1'b1;
        cyc();
        ld_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ld_valid = 1'b1; ld_data = 8'(i) ^ 8'h5A; data_m[i] = ld_data;
            cyc();
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midload_busy: busy=%b required 1", busy);
        end
        ld_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pmem_in, rd_valid, ld_ready, ld_done, wr_drop, busy} !== 13'h0) begin
            failures++;
            $display("FAIL midload_reset: pmem_in=%h rd_valid=%b ld_ready=%b ld_done=%b wr_drop=%b busy=%b required all 0",
                     pmem_in, rd_valid, ld_ready, ld_done, wr_drop, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b0 || ld_done !== 1'b0) begin
            failures++;
            $display("FAIL midload_idle: busy=%b ld_done=%b required 0 0", busy, ld_done);
        end
        rd_req = 1'b1; rd_type = 1'b1;
        for (int a = 0; a < 20; a += 19) begin
            rd_addr = 6'(a);
            exp_q.push_back(8'(a) ^ 8'h5A);
            cyc();
        end
        rd_req = 1'b0;
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_pending: pending=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pmem_we = 1'b0; pmem_d_type = 1'b0; pmem_w_addr = '0; pmem_out = '0;
        rd_req = 1'b0; rd_type = 1'b0; rd_addr = '0;
        ld_start = 1'b0; ld_type = 1'b0; ld_valid = 1'b0; ld_data = '0;
        @(negedge clk);
        test_reset();
        test_load_prog();
        test_exec_write();
        test_collision();
        test_write_during_load();
        test_restart_backpressure();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
